// File: rtl/trc_relay_pkg.sv
// Shared state encoding and step constants for the scanport relay sequencer.
// Defining TRC_TRM_REL_EN adds a fourth sequence step for the termination relay.
package trc_relay_pkg;

  localparam int DEFAULT_SETTLE_CYCLES = 5000;

  localparam int REL_GND = 0;
  localparam int REL_TAP = 1;
  localparam int REL_IO  = 2;

`ifdef TRC_TRM_REL_EN
  localparam int NUM_STEPS = 4;
  localparam int REL_TRM   = 3;
  typedef enum logic [2:0] {IDLE = 3'd0, STEP1, STEP2, STEP3, STEP4} seq_state_e;
`else
  localparam int NUM_STEPS = 3;
  typedef enum logic [2:0] {IDLE = 3'd0, STEP1, STEP2, STEP3} seq_state_e;
`endif

  // Zero-based step index of a running state.
  function automatic int step_num(seq_state_e s);
    case (s)
      STEP2:   return 1;
      STEP3:   return 2;
`ifdef TRC_TRM_REL_EN
      STEP4:   return 3;
`endif
      default: return 0;
    endcase
  endfunction

  function automatic seq_state_e step_state(int k);
    case (k)
      1:       return STEP2;
      2:       return STEP3;
`ifdef TRC_TRM_REL_EN
      3:       return STEP4;
`endif
      default: return STEP1;
    endcase
  endfunction

endpackage

// File: rtl/trc_settle_timer.sv
// Shared settle counter: load to CYCLES, count down, done while the count is 1
// so the step that follows lands exactly CYCLES edges after the load.
module trc_settle_timer
  import trc_relay_pkg::*;
#(
  parameter int CYCLES = DEFAULT_SETTLE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic load,
  output logic done
);

  localparam int W = $clog2(CYCLES + 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)                cnt_d = '0;
    else if (load)          cnt_d = W'(CYCLES);
    else if (cnt_q != '0)   cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign done = (cnt_q == W'(1));

endmodule

// File: rtl/scanport_relay_seq.sv
// Sequences gnd/tap/io relays of one scanport per command with settle delays.
// Optional TRC_TRM_REL_EN adds a termination relay as the last connect step.
module scanport_relay_seq
  import trc_relay_pkg::*;
#(
  parameter int NUM_PORTS     = 2,
  parameter int SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES
) (
  input  logic                 OSC_RC,
  input  logic                 TRC_RESET,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [2:0]           cmd_port,
  input  logic                 cmd_connect,
  input  logic                 abort_all,
  output logic [NUM_PORTS-1:0] gnd_rel,
  output logic [NUM_PORTS-1:0] tap_rel,
  output logic [NUM_PORTS-1:0] io_rel,
`ifdef TRC_TRM_REL_EN
  output logic [NUM_PORTS-1:0] trm_rel,
`endif
  output logic [NUM_PORTS-1:0] connected,
  output logic                 busy,
  output logic                 err,
  output seq_state_e           dbg_state
);

  seq_state_e                           state_q, state_d;
  logic [2:0]                           tgt_q, tgt_d;
  logic                                 conn_q, conn_d;
  logic                                 pend_q, pend_d;
  logic                                 err_q, err_d;
  logic [NUM_STEPS-1:0][NUM_PORTS-1:0]  rel_q, rel_d;
  logic [NUM_PORTS-1:0]                 con_q, con_d;
  logic                                 tmr_load, tmr_done, tgt_con, act_en;
  int                                   cur_k, act_k, act_rel;

  trc_settle_timer #(.CYCLES(SETTLE_CYCLES)) u_timer (
    .clk   (OSC_RC),
    .rst_n (TRC_RESET),
    .clr   (abort_all),
    .load  (tmr_load),
    .done  (tmr_done)
  );

  // Command handshake: a command transfers on a rising edge with cmd_valid and
  // cmd_ready both high; port/direction are latched then and checked one cycle later.
  assign cmd_ready = (state_q == IDLE) && !pend_q && !abort_all;

  always_comb begin
    state_d  = state_q;
    tgt_d    = tgt_q;
    conn_d   = conn_q;
    pend_d   = pend_q;
    err_d    = 1'b0;
    rel_d    = rel_q;
    con_d    = con_q;
    tmr_load = 1'b0;
    act_en   = 1'b0;
    act_k    = 0;
    act_rel  = 0;
    tgt_con  = 1'b0;
    cur_k    = step_num(state_q);
    for (int p = 0; p < NUM_PORTS; p++)
      if (tgt_q == 3'(p)) tgt_con = con_q[p];

    if (abort_all) begin
      state_d = IDLE;
      pend_d  = 1'b0;
      rel_d   = '0;
      con_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pend_q) begin
            pend_d = 1'b0;
            if (int'(tgt_q) >= NUM_PORTS || tgt_con == conn_q) begin
              err_d = 1'b1;
            end else begin
              state_d  = STEP1;
              tmr_load = 1'b1;
              act_en   = 1'b1;
            end
          end else if (cmd_valid && cmd_ready) begin
            tgt_d  = cmd_port;
            conn_d = cmd_connect;
            pend_d = 1'b1;
          end
        end
        default: begin
          if (tmr_done) begin
            if (cur_k == NUM_STEPS - 1) begin
              state_d = IDLE;
              for (int p = 0; p < NUM_PORTS; p++)
                if (tgt_q == 3'(p)) con_d[p] = conn_q;
            end else begin
              state_d  = step_state(cur_k + 1);
              tmr_load = 1'b1;
              act_en   = 1'b1;
              act_k    = cur_k + 1;
            end
          end
        end
      endcase

      // Connect walks relays gnd->tap->io(->trm); disconnect walks them in reverse.
      if (act_en) begin
        act_rel = conn_q ? act_k : (NUM_STEPS - 1 - act_k);
        for (int r = 0; r < NUM_STEPS; r++)
          for (int p = 0; p < NUM_PORTS; p++)
            if (r == act_rel && tgt_q == 3'(p)) rel_d[r][p] = conn_q;
      end
    end
  end

  always_ff @(posedge OSC_RC or negedge TRC_RESET) begin
    if (!TRC_RESET) begin
      state_q <= IDLE;
      tgt_q   <= '0;
      conn_q  <= 1'b0;
      pend_q  <= 1'b0;
      err_q   <= 1'b0;
      rel_q   <= '0;
      con_q   <= '0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      conn_q  <= conn_d;
      pend_q  <= pend_d;
      err_q   <= err_d;
      rel_q   <= rel_d;
      con_q   <= con_d;
    end
  end

  assign gnd_rel   = rel_q[REL_GND];
  assign tap_rel   = rel_q[REL_TAP];
  assign io_rel    = rel_q[REL_IO];
`ifdef TRC_TRM_REL_EN
  assign trm_rel   = rel_q[REL_TRM];
`endif
  assign connected = con_q;
  assign busy      = (state_q != IDLE);
  assign err       = err_q;
  assign dbg_state = state_q;

endmodule
